// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM sequencer.
package led_pwm_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SCAN} state_t;

  localparam logic MODE_SET   = 1'b0;
  localparam logic MODE_FADE  = 1'b1;
  localparam int   DEF_DUTY_W = 7;
endpackage

// File: rtl/led_pwm_tick_gen.sv
// Fade-tick prescaler: one-cycle tick every TICK_DIV clocks.
module led_pwm_tick_gen #(
  parameter int TICK_DIV = 1048576
) (
  input  logic saatDarbesi,
  input  logic reset,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge saatDarbesi or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/led_pwm_sequencer.sv
// Eight-channel LED duty controller: command handshake, round-robin fade scan,
// shared PWM counter compared against each channel's current duty.
module led_pwm_sequencer
  import led_pwm_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int TICK_DIV = 1048576
) (
  input  logic              saatDarbesi,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_led,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_mode,
  output logic              cmd_err,
  output logic              busy,
  output logic [N_LED-1:0]  LED
);
  localparam logic [3:0] NL = 4'(N_LED);

  state_t            r_state;
  logic [DUTY_W-1:0] r_cur [8];
  logic [DUTY_W-1:0] r_tgt [8];
  logic [2:0]        r_idx;
  logic [2:0]        r_cled;
  logic [DUTY_W-1:0] r_cduty;
  logic              r_cmode;
  logic              r_pend;
  logic              r_ready;
  logic              r_err;
  logic              r_busy;
  logic [DUTY_W-1:0] r_pwm;
  logic [N_LED-1:0]  r_led;
  logic              w_tick;
  logic              w_cvalid;
  logic              w_busy;
  logic [N_LED-1:0]  w_led;

  led_pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .saatDarbesi (saatDarbesi),
    .reset       (reset),
    .tick        (w_tick)
  );

  assign w_cvalid  = ({1'b0, r_cled} < NL);
  assign cmd_ready = r_ready;
  assign cmd_err   = r_err;
  assign busy      = r_busy;
  assign LED       = r_led;

  always_ff @(posedge saatDarbesi or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cled  <= '0;
      r_cduty <= '0;
      r_cmode <= MODE_SET;
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cur[i] <= '0;
        r_tgt[i] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cled  <= cmd_led;
            r_cduty <= cmd_duty;
            r_cmode <= cmd_mode;
            r_err   <= ({1'b0, cmd_led} >= NL);
            r_ready <= 1'b0;
            r_state <= APPLY;
            if (w_tick) r_pend <= 1'b1;
          end else if (w_tick || r_pend) begin
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= SCAN;
          end
        end
        APPLY: begin
          if (w_cvalid) begin
            r_tgt[r_cled] <= r_cduty;
            if (r_cmode == MODE_SET) r_cur[r_cled] <= r_cduty;
          end
          if (w_tick) r_pend <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        SCAN: begin
          // Steps only move toward the target, so they can never wrap.
          if (r_cur[r_idx] < r_tgt[r_idx])      r_cur[r_idx] <= r_cur[r_idx] + 1'b1;
          else if (r_cur[r_idx] > r_tgt[r_idx]) r_cur[r_idx] <= r_cur[r_idx] - 1'b1;
          if (w_tick) r_pend <= 1'b1;
          if (r_idx == 3'(N_LED - 1)) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b0;
    w_led  = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_led[i] = (r_pwm < r_cur[i]);
      w_busy   = w_busy | (r_cur[i] != r_tgt[i]);
    end
  end

  always_ff @(posedge saatDarbesi or posedge reset) begin
    if (reset) begin
      r_pwm  <= '0;
      r_led  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_pwm  <= r_pwm + 1'b1;
      r_led  <= w_led;
      r_busy <= w_busy;
    end
  end
endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Scoreboard bench: stimulus queues expectations, two monitors compare them
// against an 8-channel and a 4-channel instance (TICK_DIV=16).
module tb_led_pwm_sequencer;
  import led_pwm_pkg::*;

  localparam int DW = 7;
  localparam int K_DUTY = 0, K_BUSY = 1, K_RDY = 2, K_LEDS = 3, K_ERR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    c_led = '0;
  logic [DW-1:0] c_duty = '0;
  logic          c_mode = 1'b0;
  logic          v8 = 1'b0, v4 = 1'b0;
  logic          r8, r4, e8, e4, b8, b4;
  logic [7:0]    led8;
  logic [3:0]    led4;

  always #5 clk = ~clk;

  led_pwm_sequencer #(.N_LED(8), .DUTY_W(DW), .TICK_DIV(16)) u8 (
    .saatDarbesi(clk), .reset(rst), .cmd_valid(v8), .cmd_ready(r8),
    .cmd_led(c_led), .cmd_duty(c_duty), .cmd_mode(c_mode),
    .cmd_err(e8), .busy(b8), .LED(led8));

  led_pwm_sequencer #(.N_LED(4), .DUTY_W(DW), .TICK_DIV(16)) u4 (
    .saatDarbesi(clk), .reset(rst), .cmd_valid(v4), .cmd_ready(r4),
    .cmd_led(c_led), .cmd_duty(c_duty), .cmd_mode(c_mode),
    .cmd_err(e4), .busy(b4), .LED(led4));

  typedef struct {
    int    sel;
    int    kind;
    int    ch;
    int    exp;
    string name;
  } chk_t;

  chk_t chk_q[$];
  bit   acc_q0[$];
  bit   acc_q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_busy = 1'b0;

  function automatic int get_rdy(input int s);  return s == 0 ? int'(r8) : int'(r4); endfunction
  function automatic int get_busy(input int s); return s == 0 ? int'(b8) : int'(b4); endfunction
  function automatic int get_err(input int s);  return s == 0 ? int'(e8) : int'(e4); endfunction
  function automatic int get_led(input int s);  return s == 0 ? int'(led8) : int'(led4); endfunction
  function automatic int get_vld(input int s);  return s == 0 ? int'(v8) : int'(v4); endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
  endtask

  task automatic push(input int sel, input int kind, input int ch, input int exp, input string nm);
    chk_t c;
    c.sel = sel; c.kind = kind; c.ch = ch; c.exp = exp; c.name = nm;
    chk_q.push_back(c);
  endtask

  // Check monitor: compares queued expectations against live DUT outputs.
  initial begin : mon_chk
    chk_t c;
    int   cnt;
    forever begin
      @(negedge clk); #1;
      while (chk_q.size() > 0) begin
        mon_busy = 1'b1;
        c = chk_q.pop_front();
        case (c.kind)
          K_DUTY: begin
            cnt = 0;
            for (int k = 0; k < 128; k++) begin
              cnt += (get_led(c.sel) >> c.ch) & 1;
              @(negedge clk); #1;
            end
            cmp(c.name, cnt, c.exp);
          end
          K_BUSY:  cmp(c.name, get_busy(c.sel), c.exp);
          K_RDY:   cmp(c.name, get_rdy(c.sel), c.exp);
          K_LEDS:  cmp(c.name, get_led(c.sel), c.exp);
          default: cmp(c.name, get_err(c.sel), c.exp);
        endcase
      end
      mon_busy = 1'b0;
    end
  end

  // Handshake monitor: on every accept, checks the err pulse and ready drop/return.
  int st [2];
  bit ex [2];
  initial begin : mon_acc
    st[0] = 0; st[1] = 0;
    forever begin
      @(negedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (st[s] == 2) begin
          cmp("err_clear", get_err(s), 0);
          cmp("rdy_back", get_rdy(s), 1);
          st[s] = 0;
        end else if (st[s] == 1) begin
          cmp("err_pulse", get_err(s), int'(ex[s]));
          cmp("rdy_drop", get_rdy(s), 0);
          st[s] = 2;
        end
        if (st[s] == 0 && get_vld(s) == 1 && get_rdy(s) == 1) begin
          if (s == 0 && acc_q0.size() > 0)      begin ex[s] = acc_q0.pop_front(); st[s] = 1; end
          else if (s == 1 && acc_q1.size() > 0) begin ex[s] = acc_q1.pop_front(); st[s] = 1; end
          else fail("unexpected_accept");
        end
      end
    end
  end

  // Returns at the negedge after APPLY, with the DUT back in IDLE.
  task automatic send(input int sel, input int led, input int duty, input logic mode);
    int t = 0;
    c_led = 3'(led); c_duty = DW'(duty); c_mode = mode;
    if (sel == 0) begin acc_q0.push_back(1'b0); v8 = 1'b1; end
    else          begin acc_q1.push_back(led >= 4); v4 = 1'b1; end
    while (get_rdy(sel) == 0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      fail("send_timeout");
      v8 = 1'b0; v4 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0; v4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rdy(input int val);
    int t = 0;
    while (get_rdy(0) != val && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) fail("wait_ready_timeout");
  endtask

  task automatic wait_scans(input int n);
    repeat (n) begin wait_rdy(0); wait_rdy(1); end
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((chk_q.size() > 0 || mon_busy) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail("drain_timeout");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (3) @(negedge clk);
    push(0, K_RDY, 0, 1, "rst_ready");
    push(0, K_BUSY, 0, 0, "rst_busy");
    push(0, K_LEDS, 0, 0, "rst_leds");
    push(0, K_ERR, 0, 0, "rst_err");
    push(1, K_RDY, 0, 1, "rst_ready4");
    drain();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a scan
    send(0, 1, 64, MODE_SET);
    send(0, 2, 100, MODE_FADE);
    drain();
    push(0, K_DUTY, 1, 64, "pre_rst_duty1");
    drain();
    wait_rdy(1);
    wait_rdy(0);
    push(0, K_BUSY, 0, 1, "pre_rst_busy");
    #2 rst = 1'b1;
    @(negedge clk);
    push(0, K_LEDS, 0, 0, "midscan_rst_leds");
    push(0, K_RDY, 0, 1, "midscan_rst_ready");
    push(0, K_BUSY, 0, 0, "midscan_rst_busy");
    drain();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    push(0, K_DUTY, 1, 0, "post_rst_duty1");
    push(0, K_DUTY, 2, 0, "post_rst_duty2");
    push(0, K_BUSY, 0, 0, "post_rst_busy");
    drain();

    // SET: immediate duty, other channels untouched; full-scale duty
    send(0, 3, 32, MODE_SET);
    drain();
    push(0, K_DUTY, 3, 32, "set_duty3");
    push(0, K_DUTY, 5, 0, "set_other5");
    drain();
    send(0, 6, 127, MODE_SET);
    drain();
    push(0, K_DUTY, 6, 127, "set_duty6_max");
    drain();
    send(0, 6, 0, MODE_SET);
    drain();
    push(0, K_DUTY, 6, 0, "set_duty6_zero");
    drain();

    // FADE up 0 -> 5
    send(0, 0, 5, MODE_FADE);
    push(0, K_BUSY, 0, 0, "fade_busy_t1");
    @(negedge clk);
    push(0, K_BUSY, 0, 1, "fade_busy_t2");
    repeat (100) @(negedge clk);
    push(0, K_BUSY, 0, 0, "fade_busy_done");
    push(0, K_DUTY, 0, 5, "fade_duty0");
    push(0, K_DUTY, 3, 32, "fade_keep3");
    drain();

    // Fade up 3 ticks, then retarget down to 0
    send(0, 7, 10, MODE_FADE);
    wait_scans(3);
    send(0, 7, 0, MODE_FADE);
    push(0, K_BUSY, 0, 1, "retarget_busy");
    wait_scans(2);
    push(0, K_BUSY, 0, 1, "descend_busy_at1");
    wait_scans(1);
    @(negedge clk);
    push(0, K_BUSY, 0, 0, "descend_busy_done");
    push(0, K_DUTY, 7, 0, "descend_duty7");
    drain();

    // Command on the tick cycle: accept first, then the pending scan
    wait_rdy(1);
    wait_rdy(0);
    repeat (15) @(negedge clk);
    send(0, 4, 20, MODE_SET);
    @(negedge clk);
    push(0, K_RDY, 0, 0, "pend_scan_start");
    repeat (13) @(negedge clk);
    push(0, K_RDY, 0, 1, "idle_before_tick");
    @(negedge clk);
    push(0, K_RDY, 0, 0, "next_tick_scan");
    drain();
    push(0, K_DUTY, 4, 20, "collision_duty4");
    drain();

    // Invalid channel index on the 4-channel instance
    send(1, 2, 50, MODE_SET);
    send(1, 6, 100, MODE_SET);
    drain();
    push(1, K_BUSY, 0, 0, "inval_busy");
    push(1, K_DUTY, 2, 50, "inval_keep2");
    push(1, K_LEDS, 0, 0, "inval_leds_phase");
    drain();
    send(1, 5, 9, MODE_FADE);
    @(negedge clk);
    push(1, K_BUSY, 0, 0, "inval_fade_busy");
    push(1, K_DUTY, 0, 0, "inval_duty0");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_pwm_sequencer.md
# led_pwm_sequencer

Eight-channel LED brightness controller for the DE0-Nano-SoC LED bank. It accepts duty commands over a valid/ready handshake and keeps a current and a target duty per LED. A round-robin scan walks each channel's current duty toward its target by one LSB per fade tick. One shared free-running PWM counter is compared against every channel's current duty to drive `LED[7:0]`. It replaces ad-hoc per-demo PWM logic and sits directly between board-level control (HPS bridge or switch decoder) and the LED pins.

## Interface
- `N_LED`, 8, number of LED channels (1..8)
- `DUTY_W`, 7, duty and PWM counter width
- `TICK_DIV`, 1048576, clocks per fade tick (≥ N_LED+2)
- `saatDarbesi`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted this cycle
- `cmd_led`  in  3  target channel index
- `cmd_duty`  in  DUTY_W  requested duty
- `cmd_mode`  in  1  0 = SET (immediate), 1 = FADE (ramp)
- `cmd_err`  out  1  one-cycle pulse: accepted command had `cmd_led` ≥ N_LED
- `busy`  out  1  some channel has current ≠ target
- `LED`  out  N_LED  PWM outputs, active-high

The clock is one clock, `saatDarbesi`. Reset `reset` is asynchronous and active-high.

## Operation
- **State.** Per channel: `cur[i]` and `tgt[i]`, each DUTY_W bits. Shared: `pwm_cnt` (DUTY_W bits, free-running, wraps to 0), `tick_cnt` (0..TICK_DIV-1), `tick_pend` flag, scan index `idx`.
- **FSM states:** IDLE, APPLY, SCAN.
  - IDLE: `cmd_ready`=1.
    - `cmd_valid` high: latch the command and go to APPLY.
    - Else, if a tick or `tick_pend` is present: go to SCAN with `idx`=0 and clear `tick_pend`.
  - APPLY (1 cycle): `cmd_ready`=0.
    - Valid index: `tgt[cmd_led]`←`cmd_duty`. If SET, also `cur[cmd_led]`←`cmd_duty`.
    - Invalid index: no state change; `cmd_err` pulses in this cycle.
    - Then go to IDLE.
  - SCAN (N_LED cycles, one channel per cycle): `cmd_ready`=0.
    - If `cur<tgt`, `cur`+1. If `cur>tgt`, `cur`−1. Else hold.
    - After `idx`=N_LED-1, go to IDLE.
- **Tick.** A tick pulses when `tick_cnt` wraps. A tick arriving outside IDLE, or in IDLE together with `cmd_valid`, sets `tick_pend`. Commands take priority over a pending scan. At most one tick is pending; further ticks while pending are dropped. TICK_DIV ≥ N_LED+2 guarantees no loss in normal use.
- **PWM.** `LED[i]` is registered and equals `pwm_cnt < cur[i]`.
  - Duty 0 is fully off.
  - Duty 2^DUTY_W−1 is on 127 of 128 cycles.
  - Period is 2^DUTY_W clocks.
- **Busy.** `busy` is registered: OR over `cur[i]≠tgt[i]`.
- **Arithmetic.** All duty arithmetic is unsigned. ±1 steps never wrap, because a step is only taken toward `tgt`.

## Timing
- **Reset values:** `LED`=0, `cmd_ready`=1, `cmd_err`=0, `busy`=0, all `cur`/`tgt`/counters 0, state IDLE, `tick_pend`=0.
- **Reset mid-operation** (APPLY or SCAN) aborts immediately. A partially scanned fade is discarded.
- **Handshake:** a command transfers on the rising edge where `cmd_valid`&`cmd_ready`. `cmd_ready` drops the following cycle.
  - Back-to-back accepts occur at most every 2 cycles.
  - `cmd_*` must be held stable while `cmd_valid`=1 and `cmd_ready`=0.
- **SET latency:** accept at edge T → `cur` updated at edge T+1 → `LED` reflects the new duty from edge T+2.
- **Fade rate:** 1 LSB per tick per channel. A full 0→127 ramp takes 127 ticks.
- **`busy` latency:** rises 2 edges after a FADE accept that changes `tgt`. Falls 1 edge after the final scan step equalizes.
- **`cmd_err`** is high for exactly the APPLY cycle.

## Structure
- Package `led_pwm_pkg`:
  - state enum {IDLE, APPLY, SCAN}
  - mode constants MODE_SET=0, MODE_FADE=1
  - default DUTY_W
- Sub-module `led_pwm_tick_gen`: prescaler with parameter TICK_DIV, inputs `saatDarbesi` and `reset`, output a one-cycle `tick`.
- The per-channel arrays, FSM and PWM compare stay in the top level.

## Test plan
Use TICK_DIV=16 for simulation.
1. **Reset.** Assert `reset` mid-SCAN → next cycle `LED`=0, `cmd_ready`=1, `busy`=0. No channel lights after release without a new command.
2. **SET.** SET led 3 to duty 32 → `LED[3]` high exactly 32 of every 128 clocks from edge T+2. Other LEDs stay 0.
3. **FADE up.** FADE led 0 to duty 5 from 0 → `busy` rises. `cur[0]` reaches 5 after 5 ticks (about 80 clocks). `busy` then falls, and duty stays at 5.
4. **Fade down and retarget.** FADE led 7 to 10, then after 3 ticks FADE led 7 to 0 → `cur` climbs to 3, then descends to 0 with no wrap.
5. **Collision.** Hold `cmd_valid` on the tick cycle → command accepted first. SCAN starts within 2 cycles after returning to IDLE, and no tick is lost.
6. **Invalid index.** Set N_LED=4 and send SET led 6 → `cmd_err` pulses 1 cycle, no `cur`/`tgt` change, handshake completes.
